// File: rtl/rc4_encryptor.sv
// RC4 encryptor: S-box init, key schedule and keystream XOR
// over a shared 256x8 working RAM and two 32x8 message RAMs.
module rc4_encryptor #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [23:0]       secret_key,
  output logic              busy,
  output logic              done,
  output logic [7:0]        address_s,
  output logic [7:0]        data_s,
  output logic              wren_s,
  input  logic [7:0]        q_s,
  output logic [MSG_AW-1:0] address_p,
  input  logic [7:0]        q_p,
  output logic [MSG_AW-1:0] address_e,
  output logic [7:0]        data_e,
  output logic              wren_e
);

  localparam logic [4:0] IDLE     = 5'd0;
  localparam logic [4:0] INIT     = 5'd1;
  localparam logic [4:0] K_RD_I   = 5'd2;
  localparam logic [4:0] K_WAIT_I = 5'd3;
  localparam logic [4:0] K_RD_J   = 5'd4;
  localparam logic [4:0] K_WAIT_J = 5'd5;
  localparam logic [4:0] K_WR_I   = 5'd6;
  localparam logic [4:0] K_WR_J   = 5'd7;
  localparam logic [4:0] P_RD_I   = 5'd8;
  localparam logic [4:0] P_WAIT_I = 5'd9;
  localparam logic [4:0] P_RD_J   = 5'd10;
  localparam logic [4:0] P_WAIT_J = 5'd11;
  localparam logic [4:0] P_WR_I   = 5'd12;
  localparam logic [4:0] P_WR_J   = 5'd13;
  localparam logic [4:0] P_RD_F   = 5'd14;
  localparam logic [4:0] P_WAIT_F = 5'd15;
  localparam logic [4:0] P_WR_E   = 5'd16;
  localparam logic [4:0] DONE     = 5'd17;

  localparam logic [MSG_AW-1:0] K_LAST =
    MSG_AW'(MSG_LEN - 1);

  logic [4:0]        state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [MSG_AW-1:0] k;
  logic [1:0]        km;
  logic [7:0]        key_b;
  logic [7:0]        j_ksa;
  logic [7:0]        j_prga;
  logic [7:0]        f_addr;
  logic              in_prga;

  always_comb begin
    key_b = secret_key[7:0];
    unique case (1'b1)
      (km == 2'd0): key_b = secret_key[23:16];
      (km == 2'd1): key_b = secret_key[15:8];
      default:      key_b = secret_key[7:0];
    endcase
  end

  // q_s is the S[i] read; new j goes straight to the RAM
  assign j_ksa  = j + q_s + key_b;
  assign j_prga = j + q_s;
  assign f_addr = si + sj;

  assign in_prga = (state >= P_RD_I) &&
                   (state <= P_WR_E);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      km    <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            km    <= '0;
            state <= INIT;
          end
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) state <= K_RD_I;
        end
        K_RD_I:   state <= K_WAIT_I;
        K_WAIT_I: state <= K_RD_J;
        K_RD_J: begin
          si    <= q_s;
          j     <= j_ksa;
          state <= K_WAIT_J;
        end
        K_WAIT_J: state <= K_WR_I;
        K_WR_I: begin
          sj    <= q_s;
          state <= K_WR_J;
        end
        K_WR_J: begin
          i  <= i + 8'd1;
          km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
          if (i == 8'hFF) begin
            j     <= '0;
            state <= P_RD_I;
          end else begin
            state <= K_RD_I;
          end
        end
        P_RD_I: begin
          i     <= i + 8'd1;
          state <= P_WAIT_I;
        end
        P_WAIT_I: state <= P_RD_J;
        P_RD_J: begin
          si    <= q_s;
          j     <= j_prga;
          state <= P_WAIT_J;
        end
        P_WAIT_J: state <= P_WR_I;
        P_WR_I: begin
          sj    <= q_s;
          state <= P_WR_J;
        end
        P_WR_J:   state <= P_RD_F;
        P_RD_F:   state <= P_WAIT_F;
        P_WAIT_F: state <= P_WR_E;
        P_WR_E: begin
          k     <= k + 1'b1;
          state <= (k == K_LAST) ? DONE : P_RD_I;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    address_s = '0;
    data_s    = '0;
    wren_s    = 1'b0;
    address_e = '0;
    data_e    = '0;
    wren_e    = 1'b0;
    address_p = in_prga ? k : '0;
    case (state)
      INIT: begin
        wren_s    = 1'b1;
        address_s = i;
        data_s    = i;
      end
      K_RD_I,
      K_WAIT_I: address_s = i;
      K_RD_J:   address_s = j_ksa;
      K_WAIT_J: address_s = j;
      K_WR_I: begin
        wren_s    = 1'b1;
        address_s = i;
        data_s    = q_s;
      end
      K_WR_J: begin
        wren_s    = 1'b1;
        address_s = j;
        data_s    = si;
      end
      P_RD_I:   address_s = i + 8'd1;
      P_WAIT_I: address_s = i;
      P_RD_J:   address_s = j_prga;
      P_WAIT_J: address_s = j;
      P_WR_I: begin
        wren_s    = 1'b1;
        address_s = i;
        data_s    = q_s;
      end
      P_WR_J: begin
        wren_s    = 1'b1;
        address_s = j;
        data_s    = si;
      end
      P_RD_F,
      P_WAIT_F: address_s = f_addr;
      P_WR_E: begin
        address_s = f_addr;
        wren_e    = 1'b1;
        address_e = k;
        data_e    = q_s ^ q_p;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_encryptor.sv
// Bench for rc4_encryptor: RAM models, RC4 reference
// model, known-answer table, handshake/reset/boundary runs.
module tb_rc4_encryptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        start_b;
  logic [23:0] key;
  logic [23:0] key_b;

  logic       busy, done, wren_s, wren_e;
  logic [7:0] address_s, data_s, q_s, q_p, data_e;
  logic [4:0] address_p, address_e;

  logic       b_busy, b_done, b_wren_s, b_wren_e;
  logic [7:0] b_address_s, b_data_s, b_q_s, b_q_p;
  logic [7:0] b_data_e;
  logic [4:0] b_address_p, b_address_e;

  rc4_encryptor #(.MSG_LEN(32), .MSG_AW(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .secret_key(key), .busy(busy), .done(done),
    .address_s(address_s), .data_s(data_s),
    .wren_s(wren_s), .q_s(q_s),
    .address_p(address_p), .q_p(q_p),
    .address_e(address_e), .data_e(data_e),
    .wren_e(wren_e)
  );

  rc4_encryptor #(.MSG_LEN(1), .MSG_AW(5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .secret_key(key_b), .busy(b_busy),
    .done(b_done), .address_s(b_address_s),
    .data_s(b_data_s), .wren_s(b_wren_s),
    .q_s(b_q_s), .address_p(b_address_p),
    .q_p(b_q_p), .address_e(b_address_e),
    .data_e(b_data_e), .wren_e(b_wren_e)
  );

  // registered-address, unregistered-output RAMs
  logic [7:0] s_mem [256];
  logic [7:0] p_mem [32];
  logic [7:0] e_mem [32];
  logic [7:0] s_ar;
  logic [4:0] p_ar;
  logic [7:0] s2_mem [256];
  logic [7:0] p2_mem [32];
  logic [7:0] e2_mem [32];
  logic [7:0] s2_ar;
  logic [4:0] p2_ar;

  always @(posedge clk) begin
    if (wren_s) s_mem[address_s] <= data_s;
    if (wren_e) e_mem[address_e] <= data_e;
    s_ar <= address_s;
    p_ar <= address_p;
    if (b_wren_s) s2_mem[b_address_s] <= b_data_s;
    if (b_wren_e) e2_mem[b_address_e] <= b_data_e;
    s2_ar <= b_address_s;
    p2_ar <= b_address_p;
  end

  assign q_s   = s_mem[s_ar];
  assign q_p   = p_mem[p_ar];
  assign b_q_s = s2_mem[s2_ar];
  assign b_q_p = p2_mem[p2_ar];

  logic [37:0] a_outs, b_outs;
  assign a_outs = {busy, done, wren_s, wren_e,
                   address_s, data_s, address_p,
                   address_e, data_e};
  assign b_outs = {b_busy, b_done, b_wren_s,
                   b_wren_e, b_address_s, b_data_s,
                   b_address_p, b_address_e, b_data_e};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  // reference RC4 keystream, 3-byte key cycling
  logic [7:0] ks [32];

  task automatic gen_ks(input logic [23:0] kk);
    int s[256];
    int a, b, t, kb;
    for (int n = 0; n < 256; n++) s[n] = n;
    b = 0;
    for (a = 0; a < 256; a++) begin
      kb = int'(kk[(2 - (a % 3)) * 8 +: 8]);
      b = (b + s[a] + kb) % 256;
      t = s[a]; s[a] = s[b]; s[b] = t;
    end
    a = 0;
    b = 0;
    for (int n = 0; n < 32; n++) begin
      a = (a + 1) % 256;
      b = (b + s[a]) % 256;
      t = s[a]; s[a] = s[b]; s[b] = t;
      ks[n] = 8'(s[(s[a] + s[b]) % 256]);
    end
  endtask

  typedef struct {
    logic [23:0] key;
    logic [71:0] pt9;
    logic [71:0] exp9;
    bit          has_exp;
    bit          rnd;
  } vec_t;

  vec_t vt [4];

  task automatic load_pt(input vec_t v);
    for (int n = 0; n < 32; n++) begin
      if (v.rnd) p_mem[n] = 8'($urandom);
      else if (n < 9) p_mem[n] = v.pt9[71 - 8*n -: 8];
      else p_mem[n] = 8'h00;
    end
  endtask

  task automatic run_a(input logic [23:0] k_in,
                       input bit pulse_mid,
                       input bit hold_end,
                       input bit started,
                       input bit has_exp,
                       input bit rt,
                       input logic [71:0] exp9);
    int cnt, ws, dn, bad;
    logic [4:0] eaq [$];
    key = k_in;
    gen_ks(k_in);
    if (!started) begin
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    cnt = 0; ws = 0; dn = 0;
    while (cnt < 2200 && dn == 0) begin
      @(negedge clk);
      cnt++;
      if (wren_s && cnt <= 256) ws++;
      if (wren_e) eaq.push_back(address_e);
      if (pulse_mid) start = (cnt == 600 || cnt == 1900);
      if (cnt == 257) begin
        bad = 0;
        for (int n = 0; n < 256; n++)
          if (s_mem[n] !== 8'(n)) bad++;
        chk("init_sbox", 64'(bad), 64'd0);
      end
      if (done) dn = 1;
    end
    chk("done_seen", 64'(dn), 64'd1);
    chk("done_cycle", 64'(cnt), 64'd2081);
    chk("init_writes", 64'(ws), 64'd256);
    chk("ct_writes", 64'(eaq.size()), 64'd32);
    for (int n = 0; n < eaq.size(); n++)
      chk("ct_addr", 64'(eaq[n]), 64'(n));
    for (int n = 0; n < 32; n++) begin
      if (rt)
        chk("roundtrip", 64'(e_mem[n] ^ ks[n]),
            64'(p_mem[n]));
      else
        chk("ct_model", 64'(e_mem[n]),
            64'(p_mem[n] ^ ks[n]));
    end
    if (has_exp)
      for (int n = 0; n < 9; n++)
        chk("kat", 64'(e_mem[n]),
            64'(exp9[71 - 8*n -: 8]));
    if (hold_end) begin
      start = 1'b1;
      @(negedge clk);
      chk("idle_after_done", 64'({busy, done}), 64'd0);
      @(posedge clk);
      #1 start = 1'b0;
    end else begin
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
    end
  endtask

  task automatic mid_reset(input int at);
    int bad;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (at - 1) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_outs", 64'(a_outs), 64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (wren_s || wren_e || busy) bad++;
    end
    chk("mid_rst_quiet", 64'(bad), 64'd0);
  endtask

  task automatic run_b();
    int cnt, dn, nw, bad_addr;
    key_b = 24'hFFFFFF;
    for (int n = 0; n < 32; n++)
      p2_mem[n] = 8'($urandom);
    gen_ks(key_b);
    @(negedge clk) start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    cnt = 0; dn = 0; nw = 0; bad_addr = 0;
    while (cnt < 2000 && dn == 0) begin
      @(negedge clk);
      cnt++;
      if (b_wren_e) begin
        nw++;
        if (b_address_e != 5'd0) bad_addr++;
      end
      if (b_done) dn = 1;
    end
    chk("b_done_seen", 64'(dn), 64'd1);
    chk("b_done_cycle", 64'(cnt), 64'd1802);
    chk("b_ct_writes", 64'(nw), 64'd1);
    chk("b_ct_addr", 64'(bad_addr), 64'd0);
    chk("b_ct0", 64'(e2_mem[0]),
        64'(p2_mem[0] ^ ks[0]));
    @(negedge clk);
    chk("b_done_pulse", 64'(b_done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_b = 1'b0;
    key = '0; key_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_a", 64'(a_outs), 64'd0);
    chk("rst_outs_b", 64'(b_outs), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 64'(a_outs), 64'd0);

    vt[0] = '{24'h4B6579, "Plaintext",
              72'hBBF316E8D940AF0AD3, 1'b1, 1'b0};
    vt[1] = '{24'h000249, 72'd0, 72'd0, 1'b0, 1'b1};
    vt[2] = '{24'hFFFFFF, 72'd0, 72'd0, 1'b0, 1'b1};
    vt[3] = '{24'h000000, 72'd0, 72'd0, 1'b0, 1'b0};

    for (int v = 0; v < 4; v++) begin
      load_pt(vt[v]);
      run_a(vt[v].key, 1'b0, 1'b0, 1'b0,
            vt[v].has_exp, vt[v].rnd, vt[v].exp9);
    end

    load_pt(vt[0]);
    run_a(vt[0].key, 1'b1, 1'b1, 1'b0,
          1'b1, 1'b0, vt[0].exp9);
    run_a(vt[0].key, 1'b0, 1'b0, 1'b1,
          1'b1, 1'b0, vt[0].exp9);

    mid_reset(500);
    mid_reset(1900);
    load_pt(vt[1]);
    run_a(24'h000249, 1'b0, 1'b0, 1'b0,
          1'b0, 1'b1, 72'd0);

    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 64'(a_outs), 64'd0);
    @(negedge clk);
    chk("rst_start_idle", 64'(a_outs), 64'd0);

    run_b();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rc4_encryptor.md
# rc4_encryptor

Transmit-side counterpart of the codebreaking decrypt FSM. Takes a 24-bit secret key and a plaintext message held in a 32 x 8 RAM, runs RC4 (S-box init, key schedule, keystream generation) in the shared 256 x 8 working RAM (S), and writes the ciphertext into the 32 x 8 encrypted-message RAM. The decrypt FSM later reads that same RAM. Driven by a start/done handshake from the top level or a bench.

## Interface

Parameters:
- MSG_LEN, default 32: message length in bytes, range 1..32.
- MSG_AW, default 5: message address width.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin encryption. Sampled only in IDLE.
- secret_key, in, 24: key bytes. key[0]=secret_key[23:16], key[1]=[15:8], key[2]=[7:0].
- busy, out, 1: high from the first INIT cycle through the last WR_E cycle.
- done, out, 1: one-cycle pulse when the ciphertext is complete.
- address_s, out, 8: working-RAM address.
- data_s, out, 8: working-RAM write data.
- wren_s, out, 1: working-RAM write enable.
- q_s, in, 8: working-RAM read data.
- address_p, out, MSG_AW: plaintext RAM address.
- q_p, in, 8: plaintext RAM read data.
- address_e, out, MSG_AW: ciphertext RAM address.
- data_e, out, 8: ciphertext RAM write data.
- wren_e, out, 1: ciphertext RAM write enable.

## Operation

- Memory model: every RAM has a registered address and an unregistered output. q is valid in the cycle after the address is driven. Each read therefore uses one RD cycle and one WAIT cycle.
- Counters: i and j are 8-bit and wrap mod 256. k is MSG_AW bits.
- Key-byte select is i mod 3, kept as a 2-bit counter that wraps 0,1,2,0. No divider.
- IDLE: all enables low. On start=1, clear i, j, k and the mod-3 counter, then go to INIT.
- INIT, 256 cycles:
  - Write S[i]=i (wren_s=1, address_s=i, data_s=i).
  - i++. After i=255, set i=0 and go to KSA.
- KSA, 6 cycles per i, for i=0..255:
  - K_RD_I: address_s=i.
  - K_WAIT_I.
  - K_RD_J: capture si=q_s; j=j+si+key[i mod 3]; address_s=new j.
  - K_WAIT_J.
  - K_WR_I: capture sj=q_s; write S[i]=sj.
  - K_WR_J: write S[j]=si; i++.
  - After i=255: set i=0, keep j, then set j=0 and go to PRGA.
- PRGA, 9 cycles per byte, for k=0..MSG_LEN-1:
  - P_RD_I: i=i+1; address_s=i+1; address_p=k (held through P_WR_E).
  - P_WAIT_I.
  - P_RD_J: capture si; j=j+si; address_s=j.
  - P_WAIT_J.
  - P_WR_I: capture sj; write S[i]=sj.
  - P_WR_J: write S[j]=si.
  - P_RD_F: address_s=(si+sj) mod 256.
  - P_WAIT_F.
  - P_WR_E: wren_e=1, address_e=k, data_e=q_s ^ q_p; k++.
  - After the k=MSG_LEN-1 byte, go to DONE.
- DONE, 1 cycle: done=1, busy=0, then return to IDLE.
- When i==j, the two writes target the same address with the same value. No special case is needed, and the result matches reference RC4.
- start while busy is ignored. start held high across DONE re-triggers from IDLE on the next cycle.
- secret_key must be stable while busy. The block does not latch it.

## Timing

- Reset values: busy=0, done=0, wren_s=0, wren_e=0. address_s, data_s, address_p, address_e and data_e are all 0. State is IDLE; i, j and k are 0.
- Latency: the first INIT cycle follows the edge that samples start. done is high in cycle 256 + 1536 + 9·MSG_LEN + 1 after that edge, which is cycle 2081 for MSG_LEN=32.
- Write enables are high for exactly one cycle per write. Outside write states they are 0.
- Reset mid-operation: the next edge returns the block to IDLE with reset values. No further writes occur. RAM contents are left partially updated, and a new start fully reinitialises S.
- Simultaneous rst and start: rst wins, and start is not recorded.

## Test plan

- Reset: assert rst for 3 cycles, mid-KSA and mid-PRGA. Required: all outputs at reset values on the next cycle; wren_s and wren_e stay 0 until a new start.
- INIT check: start, then stop the bench at cycle 256. Required: the S model holds S[n]=n for n=0..255, and exactly 256 wren_s pulses occurred.
- RC4 vector: secret_key=24'h4B6579 ("Key"), plaintext "Plaintext" then zeros, MSG_LEN=32. Required: e[0..8] = BB F3 16 E8 D9 40 AF 0A D3; done at cycle 2081; exactly 32 wren_e pulses, at addresses 0..31 in order.
- Round-trip: secret_key=24'h000249 with random plaintext. Feed the ciphertext RAM to the decrypt FSM with the same key. Required: the decrypted RAM equals the plaintext.
- Handshake: pulse start during busy, and hold start high through DONE. Required: the in-flight run is unaffected, there is exactly one done pulse per run, and the second run starts the cycle after DONE.
- Boundary: MSG_LEN=1, secret_key=24'hFFFFFF. Required: exactly 1 ciphertext write, at address 0; done at cycle 1802; no write at address 1.
